// File: rtl/mod_n_updown_counter_if.sv
// Control and status bundle for one modulo-N up/down counter stage.
// Pure wiring. The counter drives the status half.
// No handshake: inputs are sampled every Clock edge.
interface mod_n_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             Enable;
    logic             Up_Down;
    logic             Load;
    logic [WIDTH-1:0] Load_Value;
    logic [WIDTH-1:0] Count;
    logic             Terminal_Count;
    logic             Wrap_Pulse;
    logic             Load_Error;
    logic             Overflow;

    // Side that issues commands and watches the count (stimulus / upstream control)
    modport master (
        output Enable, Up_Down, Load, Load_Value,
        input  Count, Terminal_Count, Wrap_Pulse, Load_Error, Overflow
    );

    // Counter side
    modport slave (
        input  Enable, Up_Down, Load, Load_Value,
        output Count, Terminal_Count, Wrap_Pulse, Load_Error, Overflow
    );
endinterface

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with parallel load, cascadable through Terminal_Count (MOD_COUNTER_SATURATE_EN: clamp instead of wrap).
// Latency: one Clock from Load/Enable sample to Count and flags; Terminal_Count is combinational.
// No backpressure: every edge with Clear_bar=1 is acted on (Load > Enable > hold).
module mod_n_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic                   Clock,
    input  logic                   Clear_bar,
    mod_n_updown_counter_if.slave  bus
);

    // Reject moduli that cannot be represented or make no sense as a counter
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("mod_n_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

`ifdef MOD_COUNTER_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    // One extra bit so that compares against MODULUS never alias when MODULUS = 2**WIDTH
    localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   TOP_X = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] TOP   = TOP_X[WIDTH-1:0];

    logic [WIDTH-1:0] count_q, count_nxt;
    logic             wrap_q, wrap_nxt;
    logic             lerr_q, lerr_nxt;
    logic             ovf_q, ovf_nxt;
    logic [WIDTH:0]   count_x;
    logic [WIDTH:0]   load_x;
    logic [WIDTH:0]   step_x;
    logic             at_top;
    logic             at_zero;

    assign count_x = {1'b0, count_q};
    assign load_x  = {1'b0, bus.Load_Value};
    assign at_top  = (count_x == TOP_X);
    assign at_zero = (count_q == '0);

    // Next-state: load has priority, then count, otherwise hold; pulses default low
    always_comb begin
        count_nxt = count_q;
        wrap_nxt  = 1'b0;
        lerr_nxt  = 1'b0;
        ovf_nxt   = ovf_q;
        step_x    = '0;
        if (bus.Load) begin
            ovf_nxt = 1'b0;
            if (load_x < MOD_X) begin
                count_nxt = bus.Load_Value;
            end else begin
                count_nxt = TOP;
                lerr_nxt  = 1'b1;
            end
        end else if (bus.Enable) begin
            if (bus.Up_Down) begin
                if (at_top) begin
                    if (!SATURATE) begin
                        count_nxt = '0;
                        wrap_nxt  = 1'b1;
                        ovf_nxt   = 1'b1;
                    end
                end else begin
                    step_x    = count_x + (WIDTH+1)'(1);
                    count_nxt = step_x[WIDTH-1:0];
                end
            end else begin
                if (at_zero) begin
                    if (!SATURATE) begin
                        count_nxt = TOP;
                        wrap_nxt  = 1'b1;
                        ovf_nxt   = 1'b1;
                    end
                end else begin
                    step_x    = count_x - (WIDTH+1)'(1);
                    count_nxt = step_x[WIDTH-1:0];
                end
            end
        end
    end

    // State register; Clear_bar wipes count and all flags immediately
    always_ff @(posedge Clock or negedge Clear_bar) begin
        if (!Clear_bar) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            lerr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_nxt;
            wrap_q  <= wrap_nxt;
            lerr_q  <= lerr_nxt;
            ovf_q   <= ovf_nxt;
        end
    end

    // Cascade flag: next stage may step on this edge; suppressed while loading
    assign bus.Terminal_Count = ~bus.Load & bus.Enable &
                                ((bus.Up_Down & at_top) | (~bus.Up_Down & at_zero));

    assign bus.Count      = count_q;
    assign bus.Wrap_Pulse = wrap_q;
    assign bus.Load_Error = lerr_q;
    assign bus.Overflow   = ovf_q;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Bench for mod_n_updown_counter: two cascaded decade stages (lo feeds hi.Enable).
// Each row drives inputs just after a rising edge and queues what the mid-cycle sample must show.
// A negedge monitor pops and compares, so stimulus and checking run independently.
module tb_mod_n_updown_counter;

    typedef struct {
        logic [3:0] cnt;
        logic       tc;
        logic       wrap;
        logic       lerr;
        logic       ovf;
        logic [3:0] hi;
        bit         chk_flags;
        bit         chk_hi;
    } exp_t;

    logic Clock;
    logic Clear_bar;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    mod_n_updown_counter_if #(.WIDTH(4)) lo_if ();
    mod_n_updown_counter_if #(.WIDTH(4)) hi_if ();

    assign hi_if.Enable     = lo_if.Terminal_Count;
    assign hi_if.Up_Down    = lo_if.Up_Down;
    assign hi_if.Load       = lo_if.Load;
    assign hi_if.Load_Value = 4'd0;

    mod_n_updown_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
        .Clock     (Clock),
        .Clear_bar (Clear_bar),
        .bus       (lo_if.slave)
    );

    mod_n_updown_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
        .Clock     (Clock),
        .Clear_bar (Clear_bar),
        .bus       (hi_if.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, req);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, req);
        end
    endtask

    // Monitor: one queued expectation per cycle, sampled mid-cycle
    always @(negedge Clock) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk4("count", lo_if.Count, mon_e.cnt);
            if (mon_e.chk_flags) begin
                chk1("terminal_count", lo_if.Terminal_Count, mon_e.tc);
                chk1("wrap_pulse", lo_if.Wrap_Pulse, mon_e.wrap);
                chk1("load_error", lo_if.Load_Error, mon_e.lerr);
                chk1("overflow", lo_if.Overflow, mon_e.ovf);
            end
            if (mon_e.chk_hi)
                chk4("hi_count", hi_if.Count, mon_e.hi);
        end
    end

    // Drive one cycle of inputs; expected values describe this cycle (state from the previous edge)
    task automatic vec(input logic en, input logic ud, input logic ld, input logic [3:0] lv,
                       input logic [3:0] c, input logic tc, input logic w,
                       input logic le, input logic ov);
        exp_t e;
        @(posedge Clock);
        #1;
        lo_if.Enable     = en;
        lo_if.Up_Down    = ud;
        lo_if.Load       = ld;
        lo_if.Load_Value = lv;
        e.cnt = c; e.tc = tc; e.wrap = w; e.lerr = le; e.ovf = ov;
        e.hi = 4'd0; e.chk_flags = 1'b1; e.chk_hi = 1'b0;
        exp_q.push_back(e);
    endtask

    // Cascade row: only the two counts are checked
    task automatic cvec(input logic en, input logic ud, input logic ld,
                        input logic [3:0] c_lo, input logic [3:0] c_hi, input bit use_hi);
        exp_t e;
        @(posedge Clock);
        #1;
        lo_if.Enable     = en;
        lo_if.Up_Down    = ud;
        lo_if.Load       = ld;
        lo_if.Load_Value = 4'd0;
        e.cnt = c_lo; e.tc = 1'b0; e.wrap = 1'b0; e.lerr = 1'b0; e.ovf = 1'b0;
        e.hi = c_hi; e.chk_flags = 1'b0; e.chk_hi = use_hi;
        exp_q.push_back(e);
    endtask

    // Change Clear_bar just after an edge; everything must read zero this cycle
    task automatic rst_set(input logic v);
        exp_t e;
        @(posedge Clock);
        #1;
        Clear_bar        = v;
        lo_if.Enable     = 1'b0;
        lo_if.Up_Down    = 1'b0;
        lo_if.Load       = 1'b0;
        lo_if.Load_Value = 4'd0;
        e.cnt = 4'd0; e.tc = 1'b0; e.wrap = 1'b0; e.lerr = 1'b0; e.ovf = 1'b0;
        e.hi = 4'd0; e.chk_flags = 1'b1; e.chk_hi = 1'b1;
        exp_q.push_back(e);
    endtask

    initial begin
        Clear_bar        = 1'b0;
        lo_if.Enable     = 1'b0;
        lo_if.Up_Down    = 1'b0;
        lo_if.Load       = 1'b0;
        lo_if.Load_Value = 4'd0;

        // Power-up reset and release
        rst_set(1'b0);
        rst_set(1'b1);
        vec(0, 1, 0, 4'd0,   4'd0, 0, 0, 0, 0);

        // Reach Count=7, then assert Clear_bar between edges
`ifdef MOD_COUNTER_SATURATE_EN
        vec(0, 0, 1, 4'd7,   4'd0, 0, 0, 0, 0);
        vec(0, 0, 0, 4'd0,   4'd7, 0, 0, 0, 0);
`else
        vec(1, 0, 0, 4'd0,   4'd0, 1, 0, 0, 0);
        vec(1, 0, 0, 4'd0,   4'd9, 0, 1, 0, 1);
        vec(1, 0, 0, 4'd0,   4'd8, 0, 0, 0, 1);
        vec(0, 0, 0, 4'd0,   4'd7, 0, 0, 0, 1);
`endif
        rst_set(1'b0);
        rst_set(1'b1);
        vec(0, 1, 0, 4'd0,   4'd0, 0, 0, 0, 0);
        vec(0, 1, 0, 4'd0,   4'd0, 0, 0, 0, 0);

        // Load range and priority over Enable; Terminal_Count masked during load
        vec(1, 1, 1, 4'd13,  4'd0, 0, 0, 0, 0);
        vec(1, 1, 1, 4'd4,   4'd9, 0, 0, 1, 0);
        vec(0, 1, 1, 4'd10,  4'd4, 0, 0, 0, 0);
        vec(0, 0, 1, 4'd9,   4'd9, 0, 0, 1, 0);
        vec(0, 0, 1, 4'd0,   4'd9, 0, 0, 0, 0);
        vec(0, 1, 0, 4'd0,   4'd0, 0, 0, 0, 0);

`ifdef MOD_COUNTER_SATURATE_EN
        // Clamp at the top
        vec(0, 1, 1, 4'd8,   4'd0, 0, 0, 0, 0);
        vec(1, 1, 0, 4'd0,   4'd8, 0, 0, 0, 0);
        vec(1, 1, 0, 4'd0,   4'd9, 1, 0, 0, 0);
        vec(1, 1, 0, 4'd0,   4'd9, 1, 0, 0, 0);
        vec(0, 0, 1, 4'd1,   4'd9, 0, 0, 0, 0);
        // Clamp at zero
        vec(1, 0, 0, 4'd0,   4'd1, 0, 0, 0, 0);
        vec(1, 0, 0, 4'd0,   4'd0, 1, 0, 0, 0);
        vec(1, 0, 0, 4'd0,   4'd0, 1, 0, 0, 0);
        vec(0, 0, 0, 4'd0,   4'd0, 0, 0, 0, 0);
`else
        // Up through the 9 -> 0 wrap
        vec(1, 1, 0, 4'd0,   4'd0, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++)
            vec(1, 1, 0, 4'd0, 4'(k), 0, 0, 0, 0);
        vec(1, 1, 0, 4'd0,   4'd9, 1, 0, 0, 0);
        vec(0, 1, 0, 4'd0,   4'd0, 0, 1, 0, 1);
        vec(0, 1, 0, 4'd0,   4'd0, 0, 0, 0, 1);

        // Load 2 then down through the 0 -> 9 wrap
        vec(1, 0, 1, 4'd2,   4'd0, 0, 0, 0, 1);
        vec(1, 0, 0, 4'd0,   4'd2, 0, 0, 0, 0);
        vec(1, 0, 0, 4'd0,   4'd1, 0, 0, 0, 0);
        vec(1, 0, 0, 4'd0,   4'd0, 1, 0, 0, 0);
        vec(1, 0, 0, 4'd0,   4'd9, 0, 1, 0, 1);
        vec(0, 0, 0, 4'd0,   4'd8, 0, 0, 0, 1);

        // Out-of-range load clears the sticky overflow
        vec(1, 1, 1, 4'd13,  4'd8, 0, 0, 0, 1);
        vec(0, 0, 0, 4'd0,   4'd9, 0, 0, 1, 0);
        vec(0, 0, 0, 4'd0,   4'd9, 0, 0, 0, 0);

        // Two-digit cascade: 25 up, then 6 down
        cvec(0, 1, 1, 4'd9, 4'd0, 1'b0);
        for (int k = 0; k < 25; k++)
            cvec(1, 1, 0, 4'(k % 10), 4'(k / 10), 1'b1);
        for (int j = 0; j < 6; j++)
            cvec(1, 0, 0, 4'((25 - j) % 10), 4'((25 - j) / 10), 1'b1);
        cvec(0, 0, 0, 4'd9, 4'd1, 1'b1);
`endif

        // Let the monitor drain, bounded
        for (int i = 0; i < 5 && exp_q.size() != 0; i++)
            @(negedge Clock);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
